// File: rtl/hub75_pkg.sv
// Shared types, widths and drain-FSM encoding for the HUB75 receive path.
package hub75_pkg;

    typedef logic [2:0] color_t;
    typedef logic [5:0] pixel_pair_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_ACTIVE
    } drain_state_t;

    localparam int unsigned DEFAULT_COLS = 64;
    localparam int unsigned DEFAULT_ROWS = 32;

    function automatic int unsigned row_sel_width(input int unsigned rows);
        return $clog2(rows / 2);
    endfunction

    function automatic int unsigned addr_width(input int unsigned cols, input int unsigned rows);
        return $clog2(cols * rows);
    endfunction

    localparam int unsigned ROW_SEL_W  = row_sel_width(DEFAULT_ROWS);
    localparam int unsigned PIX_ADDR_W = addr_width(DEFAULT_COLS, DEFAULT_ROWS);

endpackage

// File: rtl/hub75_line_buffer.sv
// Two ping-pong row banks of {upper,lower} pixels, each with a {full, row, count}
// descriptor; one write port for shifting, one combinational read port for draining.
module hub75_line_buffer
    import hub75_pkg::*;
#(
    parameter int unsigned COLS  = DEFAULT_COLS,
    parameter int unsigned ROW_W = ROW_SEL_W,
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned CNT_W = $clog2(COLS + 1)
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [COL_W-1:0]  wr_col,
    input  pixel_pair_t       wr_data,
    input  logic              commit_en,
    input  logic              commit_bank,
    input  logic [ROW_W-1:0]  commit_row,
    input  logic [CNT_W-1:0]  commit_count,
    input  logic              free_en,
    input  logic              free_bank,
    input  logic              rd_bank,
    input  logic [COL_W-1:0]  rd_col,
    output pixel_pair_t       rd_data,
    output logic [ROW_W-1:0]  rd_row,
    output logic [CNT_W-1:0]  rd_count,
    output logic [1:0]        full
);

    pixel_pair_t      mem [2][COLS];
    logic [1:0]       full_q;
    logic [ROW_W-1:0] row_q [2];
    logic [CNT_W-1:0] count_q [2];

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_bank][wr_col] <= wr_data;
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                row_q[b]   <= '0;
                count_q[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (commit_en && commit_bank == 1'(b)) begin
                    full_q[b]  <= 1'b1;
                    row_q[b]   <= commit_row;
                    count_q[b] <= commit_count;
                end else if (free_en && free_bank == 1'(b)) begin
                    full_q[b] <= 1'b0;
                end
            end
        end
    end

    assign rd_data  = mem[rd_bank][rd_col];
    assign rd_row   = row_q[rd_bank];
    assign rd_count = count_q[rd_bank];
    assign full     = full_q;

endmodule

// File: rtl/hub75_receiver.sv
// Samples a HUB75 bus, rebuilds each latched row in a ping-pong line buffer and
// replays it as a one-pixel-per-cycle frame-memory write stream.
module hub75_receiver
    import hub75_pkg::*;
#(
    parameter int unsigned MATRIX_COLS = DEFAULT_COLS,
    parameter int unsigned MATRIX_ROWS = DEFAULT_ROWS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                       i_clk,
    input  logic                                       rst,
    input  logic                                       i_hub_clk,
    input  logic                                       i_hub_latch,
    input  logic                                       i_hub_oe,
    input  logic [$clog2(MATRIX_ROWS/2)-1:0]           i_hub_row_sel,
    input  logic [2:0]                                 i_hub_color1,
    input  logic [2:0]                                 i_hub_color2,
    output logic [$clog2(MATRIX_COLS*MATRIX_ROWS)-1:0] o_pixel_addr,
    output logic [2:0]                                 o_pixel_data,
    output logic                                       o_pixel_we,
    output logic                                       o_row_done,
    output logic                                       o_overflow,
    output logic                                       o_framing_err
);

    localparam int unsigned ROW_W  = row_sel_width(MATRIX_ROWS);
    localparam int unsigned PIX_AW = addr_width(MATRIX_COLS, MATRIX_ROWS);
    localparam int unsigned COL_W  = $clog2(MATRIX_COLS);
    localparam int unsigned CNT_W  = $clog2(MATRIX_COLS + 1);
    localparam int unsigned BUS_W  = 3 + ROW_W + 6;
    localparam logic [CNT_W-1:0]  FULL_COUNT   = CNT_W'(MATRIX_COLS);
    localparam logic [PIX_AW-1:0] LOWER_OFFSET = PIX_AW'(MATRIX_COLS * MATRIX_ROWS / 2);

    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic             s_clk, s_latch, s_oe;
    logic [ROW_W-1:0] s_row;
    color_t           s_c1, s_c2;
    logic             prev_clk, prev_latch, shift_rise, latch_rise;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_clk   <= 1'b0;
            prev_latch <= 1'b0;
        end else begin
            sync_q[0] <= {i_hub_clk, i_hub_latch, i_hub_oe, i_hub_row_sel, i_hub_color1, i_hub_color2};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_clk   <= s_clk;
            prev_latch <= s_latch;
        end
    end

    assign {s_clk, s_latch, s_oe, s_row, s_c1, s_c2} = sync_q[SYNC_STAGES-1];
    assign shift_rise = s_clk & ~prev_clk;
    assign latch_rise = s_latch & ~prev_latch;

    logic             fill_bank, fill_blocked, fill_busy;
    logic             shift_take, shift_store, commit_en, framing_hit;
    logic [CNT_W-1:0] col_cnt, count_at_latch;
    logic             overflow_q, framing_q;

    drain_state_t     state_q, state_d;
    logic             drain_bank, d_lower, last_write, start_now, skip_empty, lb_free;
    logic [COL_W-1:0] d_col;
    logic [PIX_AW-1:0] upper_addr;

    pixel_pair_t      lb_rd_data;
    logic [ROW_W-1:0] lb_rd_row;
    logic [CNT_W-1:0] lb_rd_count;
    logic [1:0]       lb_full;

    // A bank being freed this very cycle may be refilled; the drain has already read it.
    assign fill_busy      = lb_full[fill_bank] && !(lb_free && drain_bank == fill_bank);
    assign shift_take     = shift_rise && (col_cnt < FULL_COUNT);
    assign shift_store    = shift_take && !fill_busy;
    assign count_at_latch = shift_take ? col_cnt + CNT_W'(1) : col_cnt;
    assign commit_en      = latch_rise && !fill_busy && !fill_blocked;
    assign framing_hit    = latch_rise && ((count_at_latch != FULL_COUNT) || !s_oe);

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            col_cnt      <= '0;
            fill_bank    <= 1'b0;
            fill_blocked <= 1'b0;
            overflow_q   <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            if (latch_rise) begin
                col_cnt      <= '0;
                fill_blocked <= 1'b0;
            end else if (shift_take) begin
                col_cnt <= col_cnt + CNT_W'(1);
                if (fill_busy) fill_blocked <= 1'b1;
            end
            if (commit_en) fill_bank <= ~fill_bank;
            if (latch_rise && !commit_en) overflow_q <= 1'b1;
            if (framing_hit) framing_q <= 1'b1;
        end
    end

    assign o_overflow    = overflow_q;
    assign o_framing_err = framing_q;

    hub75_line_buffer #(
        .COLS  (MATRIX_COLS),
        .ROW_W (ROW_W)
    ) u_line_buffer (
        .i_clk        (i_clk),
        .rst          (rst),
        .wr_en        (shift_store),
        .wr_bank      (fill_bank),
        .wr_col       (col_cnt[COL_W-1:0]),
        .wr_data      ({s_c1, s_c2}),
        .commit_en    (commit_en),
        .commit_bank  (fill_bank),
        .commit_row   (s_row),
        .commit_count (count_at_latch),
        .free_en      (lb_free),
        .free_bank    (drain_bank),
        .rd_bank      (drain_bank),
        .rd_col       (d_col),
        .rd_data      (lb_rd_data),
        .rd_row       (lb_rd_row),
        .rd_count     (lb_rd_count),
        .full         (lb_full)
    );

    // Drain may start straight off a commit into the bank it is pointing at.
    assign start_now  = (lb_full[drain_bank] && lb_rd_count != '0)
                     || (commit_en && fill_bank == drain_bank && count_at_latch != '0);
    assign skip_empty = (state_q == DRAIN_IDLE) && lb_full[drain_bank] && lb_rd_count == '0;
    assign last_write = (state_q == DRAIN_ACTIVE) && d_lower
                     && (CNT_W'(d_col) + CNT_W'(1) == lb_rd_count);
    assign upper_addr = PIX_AW'(d_col) + PIX_AW'(MATRIX_COLS) * PIX_AW'(lb_rd_row);

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q    <= DRAIN_IDLE;
            drain_bank <= 1'b0;
            d_col      <= '0;
            d_lower    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (lb_free) drain_bank <= ~drain_bank;
            if (state_q == DRAIN_ACTIVE && !last_write) begin
                d_lower <= ~d_lower;
                if (d_lower) d_col <= d_col + COL_W'(1);
            end else begin
                d_col   <= '0;
                d_lower <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAIN_IDLE:   if (start_now) state_d = DRAIN_ACTIVE;
            DRAIN_ACTIVE: if (last_write) state_d = DRAIN_IDLE;
            default:      state_d = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        o_pixel_we   = 1'b0;
        o_row_done   = 1'b0;
        o_pixel_addr = '0;
        o_pixel_data = '0;
        lb_free      = skip_empty;
        if (state_q == DRAIN_ACTIVE) begin
            o_pixel_we   = 1'b1;
            o_row_done   = last_write;
            lb_free      = last_write;
            o_pixel_addr = d_lower ? upper_addr + LOWER_OFFSET : upper_addr;
            o_pixel_data = d_lower ? lb_rd_data[2:0] : lb_rd_data[5:3];
        end
    end

endmodule

// File: tb/tb_hub75_receiver.sv
// Directed bench: drives HUB75 rows and checks the replayed write stream.
module tb_hub75_receiver;

    logic        i_clk = 1'b0;
    logic        rst = 1'b1;
    logic        hub_clk = 1'b0, hub_latch = 1'b0, hub_oe = 1'b1;
    logic [3:0]  hub_row = '0;
    logic [2:0]  c1 = '0, c2 = '0;
    logic [10:0] pix_addr;
    logic [2:0]  pix_data;
    logic        pix_we, row_done, overflow, framing_err;

    int unsigned n_vec = 0, n_err = 0;
    int unsigned cyc = 0, done_cnt = 0;
    int unsigned log_addr[$], log_data[$], log_cyc[$];

    hub75_receiver #(
        .MATRIX_COLS (64),
        .MATRIX_ROWS (32),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk         (i_clk),
        .rst           (rst),
        .i_hub_clk     (hub_clk),
        .i_hub_latch   (hub_latch),
        .i_hub_oe      (hub_oe),
        .i_hub_row_sel (hub_row),
        .i_hub_color1  (c1),
        .i_hub_color2  (c2),
        .o_pixel_addr  (pix_addr),
        .o_pixel_data  (pix_data),
        .o_pixel_we    (pix_we),
        .o_row_done    (row_done),
        .o_overflow    (overflow),
        .o_framing_err (framing_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc = cyc + 1;

    always @(negedge i_clk) begin
        if (pix_we === 1'b1) begin
            log_addr.push_back(32'(pix_addr));
            log_data.push_back(32'(pix_data));
            log_cyc.push_back(cyc);
        end
        if (row_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    function automatic logic [2:0] pat1(input int unsigned kind, input int unsigned c);
        if (kind == 0) return 3'b101;
        return 3'(c ^ (c >> 3));
    endfunction

    function automatic logic [2:0] pat2(input int unsigned kind, input int unsigned c);
        if (kind == 0) return 3'b010;
        return 3'(c * 3 + 1);
    endfunction

    task automatic shift_px(input logic [2:0] a, input logic [2:0] b, input int unsigned ph);
        hub_clk = 1'b0; c1 = a; c2 = b;
        tick(ph);
        hub_clk = 1'b1;
        tick(ph);
    endtask

    task automatic latch_row();
        hub_latch = 1'b1;
        tick(2);
        hub_latch = 1'b0; hub_clk = 1'b0;
        tick(2);
    endtask

    task automatic send_row(input int unsigned row, input int unsigned n, input int unsigned kind,
                            input int unsigned ph);
        hub_row = 4'(row);
        for (int unsigned c = 0; c < n; c++) shift_px(pat1(kind, c), pat2(kind, c), ph);
        latch_row();
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic check_row(input string tag, input int unsigned start, input int unsigned row,
                             input int unsigned n, input int unsigned kind);
        if (log_addr.size() < start + 2 * n) begin
            check({tag, "_len"}, log_addr.size(), start + 2 * n);
            return;
        end
        for (int unsigned c = 0; c < n; c++) begin
            int unsigned i;
            i = start + 2 * c;
            check($sformatf("%s_hi_addr[%0d]", tag, c), log_addr[i], c + 64 * row);
            check($sformatf("%s_hi_data[%0d]", tag, c), log_data[i], 32'(pat1(kind, c)));
            check($sformatf("%s_lo_addr[%0d]", tag, c), log_addr[i+1], c + 64 * row + 1024);
            check($sformatf("%s_lo_data[%0d]", tag, c), log_data[i+1], 32'(pat2(kind, c)));
        end
        check({tag, "_burst"}, log_cyc[start + 2 * n - 1] - log_cyc[start], 2 * n - 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"}, 32'(pix_we), 0);
        check({tag, "_row_done"}, 32'(row_done), 0);
        check({tag, "_addr"}, 32'(pix_addr), 0);
        check({tag, "_data"}, 32'(pix_data), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_framing"}, 32'(framing_err), 0);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        check_idle_outputs("reset");

        // Full row, constant colors, row pair 5
        clear_log();
        send_row(5, 64, 0, 2);
        tick(300);
        check("row5_writes", log_addr.size(), 128);
        check_row("row5", 0, 5, 64, 0);
        check("row5_done", done_cnt, 1);
        check("row5_framing", 32'(framing_err), 0);
        check("row5_overflow", 32'(overflow), 0);

        // 64th shift edge and latch edge in the same cycle
        clear_log();
        hub_row = 4'd9;
        for (int unsigned c = 0; c < 63; c++) shift_px(pat1(1, c), pat2(1, c), 2);
        hub_clk = 1'b0; c1 = pat1(1, 63); c2 = pat2(1, 63);
        tick(2);
        hub_clk = 1'b1; hub_latch = 1'b1;
        tick(2);
        hub_latch = 1'b0; hub_clk = 1'b0;
        tick(300);
        check("sim_writes", log_addr.size(), 128);
        check_row("sim", 0, 9, 64, 1);
        check("sim_done", done_cnt, 1);
        check("sim_framing", 32'(framing_err), 0);

        // Short row: latch after 10 shift clocks
        clear_log();
        send_row(2, 10, 1, 2);
        tick(300);
        check("short_writes", log_addr.size(), 20);
        check_row("short", 0, 2, 10, 1);
        check("short_done", done_cnt, 1);
        check("short_framing", 32'(framing_err), 1);
        check("short_overflow", 32'(overflow), 0);

        // Reset in the middle of a drain
        clear_log();
        send_row(7, 64, 0, 2);
        for (int unsigned i = 0; i < 300 && log_addr.size() < 10; i++) tick(1);
        check("mid_drain_reached", 32'(log_addr.size() >= 10), 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick(2);
        rst = 1'b0;
        tick(4);
        clear_log();
        send_row(7, 64, 1, 2);
        tick(300);
        check("after_rst_writes", log_addr.size(), 128);
        check_row("after_rst", 0, 7, 64, 1);
        check("after_rst_done", done_cnt, 1);
        check("after_rst_overflow", 32'(overflow), 0);

        // Three latches while the first row is still draining
        clear_log();
        send_row(3, 64, 1, 1);
        send_row(4, 4, 1, 1);
        send_row(6, 4, 0, 1);
        tick(400);
        check("ovf_writes", log_addr.size(), 136);
        check_row("ovf_a", 0, 3, 64, 1);
        check_row("ovf_b", 128, 4, 4, 1);
        check("ovf_done", done_cnt, 2);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_framing", 32'(framing_err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
